// File: rtl/bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// bus_rr_arbiter
//   Round-robin arbiter for a shared WIDTH-bit datapath bus. It takes NSRC
//   requesting sources and drives the bus through a registered output.
//   Grants are one-hot, so two sources can never drive the bus at once.
//   Each tenure lasts at most MAX_HOLD cycles while other sources are waiting.
//   The owner can hold the bus longer by keeping lock high.
//
// Ports
//   clk        rising-edge clock
//   clr        asynchronous active-high reset
//   req        per-source level request            [NSRC]
//   src_data   packed source data, source i at [i*WIDTH +: WIDTH]
//   lock       owner keeps the bus past MAX_HOLD while high
//   gnt        registered one-hot grant, zero when idle   [NSRC]
//   bus_out    registered bus value                       [WIDTH]
//   bus_valid  bus_out carries the granted source's data
//   handover   one-cycle pulse when ownership moves directly to a new owner
// -----------------------------------------------------------------------------
module bus_rr_arbiter #(
  parameter int WIDTH    = 32,
  parameter int NSRC     = 24,
  parameter int MAX_HOLD = 4
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [NSRC-1:0]         req,
  input  logic [NSRC*WIDTH-1:0]   src_data,
  input  logic                    lock,
  output logic [NSRC-1:0]         gnt,
  output logic [WIDTH-1:0]        bus_out,
  output logic                    bus_valid,
  output logic                    handover
);

  localparam int IDX_W  = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(NSRC - 1);

  typedef enum logic {IDLE, OWN} state_t;

  // Increment the tenure counter and saturate it at MAX_HOLD. A lone
  // requester can then own the bus forever without the counter wrapping.
  function automatic logic [HOLD_W-1:0] satInc(input logic [HOLD_W-1:0] cnt);
    if (cnt >= HOLD_MAX) return HOLD_MAX;
    return cnt + HOLD_W'(1);
  endfunction

  function automatic logic [NSRC-1:0] oneHot(input logic [IDX_W-1:0] idx);
    return {{(NSRC-1){1'b0}}, 1'b1} << idx;
  endfunction

  state_t             state, stateNext;
  logic [IDX_W-1:0]   last, lastNext;
  logic [HOLD_W-1:0]  holdCnt, holdNext;
  logic [NSRC-1:0]    gntNext;
  logic [WIDTH-1:0]   busNext;
  logic               validNext, handoverNext;

  logic [WIDTH-1:0]   srcArr [NSRC];
  logic [IDX_W-1:0]   winAny, winOther;
  logic               anyFound, otherFound;

  always_comb begin
    for (int i = 0; i < NSRC; i++) srcArr[i] = src_data[i*WIDTH +: WIDTH];
  end

  // Rotating priority scan that starts just after the last owner. winAny
  // covers every source and is used from IDLE. winOther leaves out the
  // current owner (last) and is used for a handover or a forced rotation.
  always_comb begin
    winAny     = last;
    anyFound   = 1'b0;
    winOther   = last;
    otherFound = 1'b0;
    for (int k = 1; k <= NSRC; k++) begin
      int cand;
      cand = (int'(last) + k) % NSRC;
      if (!anyFound && req[cand]) begin
        anyFound = 1'b1;
        winAny   = IDX_W'(cand);
      end
      if (k < NSRC && !otherFound && req[cand]) begin
        otherFound = 1'b1;
        winOther   = IDX_W'(cand);
      end
    end
  end

  // Next-state decision. While in OWN, the owner is always 'last'.
  always_comb begin
    stateNext    = state;
    lastNext     = last;
    holdNext     = holdCnt;
    gntNext      = gnt;
    busNext      = bus_out;
    validNext    = bus_valid;
    handoverNext = 1'b0;
    unique case (state)
      IDLE: begin
        if (anyFound) begin
          stateNext = OWN;
          gntNext   = oneHot(winAny);
          busNext   = srcArr[winAny];
          validNext = 1'b1;
          holdNext  = HOLD_W'(1);
          lastNext  = winAny;
        end
      end
      OWN: begin
        if (!req[last] && !otherFound) begin
          // Bus released with nobody waiting. bus_out keeps its last value.
          stateNext = IDLE;
          gntNext   = '0;
          validNext = 1'b0;
        end else if (!req[last] ||
                     (holdCnt == HOLD_MAX && !lock && otherFound)) begin
          // Move straight to the next waiter, with no idle bubble.
          gntNext      = oneHot(winOther);
          busNext      = srcArr[winOther];
          holdNext     = HOLD_W'(1);
          lastNext     = winOther;
          handoverNext = 1'b1;
        end else begin
          busNext  = srcArr[last];
          holdNext = satInc(holdCnt);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // ---- registered outputs / state ----
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      last      <= LAST_RST;
      holdCnt   <= '0;
      gnt       <= '0;
      bus_out   <= '0;
      bus_valid <= 1'b0;
      handover  <= 1'b0;
    end else begin
      state     <= stateNext;
      last      <= lastNext;
      holdCnt   <= holdNext;
      gnt       <= gntNext;
      bus_out   <= busNext;
      bus_valid <= validNext;
      handover  <= handoverNext;
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_rr_arbiter
//   Self-checking bench for bus_rr_arbiter (WIDTH=32, NSRC=24, MAX_HOLD=4).
//   It applies a table of per-cycle vectors plus hand-written sequences for
//   asynchronous clear and data tracking. Expected results pass through a
//   scoreboard queue.
// -----------------------------------------------------------------------------
module tb_bus_rr_arbiter;
  localparam int WIDTH    = 32;
  localparam int NSRC     = 24;
  localparam int MAX_HOLD = 4;

  logic                  clk = 1'b0;
  logic                  clr;
  logic [NSRC-1:0]       req;
  logic [NSRC*WIDTH-1:0] srcData;
  logic                  lock;
  logic [NSRC-1:0]       gnt;
  logic [WIDTH-1:0]      busOut;
  logic                  busValid;
  logic                  handover;

  logic [WIDTH-1:0]      srcVal [NSRC];

  bus_rr_arbiter #(.WIDTH(WIDTH), .NSRC(NSRC), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .clr       (clr),
    .req       (req),
    .src_data  (srcData),
    .lock      (lock),
    .gnt       (gnt),
    .bus_out   (busOut),
    .bus_valid (busValid),
    .handover  (handover)
  );

  always #5 clk = ~clk;

  always_comb begin
    srcData = '0;
    for (int i = 0; i < NSRC; i++) srcData[i*WIDTH +: WIDTH] = srcVal[i];
  end

  typedef struct {
    logic            rst;
    logic [NSRC-1:0] req;
    logic            lock;
    logic [NSRC-1:0] gnt;
    logic            valid;
    logic            ho;
    int              busSrc;
  } vec_t;

  typedef struct {
    logic [NSRC-1:0]  gnt;
    logic             valid;
    logic             ho;
    logic [WIDTH-1:0] bus;
    string            name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [NSRC-1:0] rq, input logic lk,
                     input logic [NSRC-1:0] g, input logic v, input logic h,
                     input int b);
    vec_t x;
    x.rst = r; x.req = rq; x.lock = lk; x.gnt = g; x.valid = v; x.ho = h;
    x.busSrc = b;
    vecs.push_back(x);
  endtask

  // Drive one cycle of stimulus, push its expectation, then pop and compare
  // after the clock edge.
  task automatic step(input logic [NSRC-1:0] r, input logic l,
                      input logic [NSRC-1:0] g, input logic v, input logic h,
                      input logic [WIDTH-1:0] b, input string nm);
    exp_t e;
    req  = r;
    lock = l;
    e.gnt = g; e.valid = v; e.ho = h; e.bus = b; e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb.pop_front();
      chk({e.name, ".gnt"},      64'(gnt),      64'(e.gnt));
      chk({e.name, ".valid"},    64'(busValid), 64'(e.valid));
      chk({e.name, ".handover"}, 64'(handover), 64'(e.ho));
      chk({e.name, ".bus"},      64'(busOut),   64'(e.bus));
    end
  endtask

  // Pulse clr between clock edges. The outputs must clear without an edge.
  task automatic pulseClr(input string nm);
    clr = 1'b1;
    #1;
    chk({nm, ".rst_gnt"},   64'(gnt),      64'd0);
    chk({nm, ".rst_bus"},   64'(busOut),   64'd0);
    chk({nm, ".rst_valid"}, 64'(busValid), 64'd0);
    chk({nm, ".rst_ho"},    64'(handover), 64'd0);
    clr = 1'b0;
  endtask

  // Invariants checked on every cycle outside reset.
  always @(negedge clk) begin
    if (clr === 1'b0) begin
      checks++;
      if (!$onehot0(gnt) || (busValid !== (|gnt))) begin
        errors++;
        $display("FAIL invariant: gnt=0x%0h bus_valid=%0b", gnt, busValid);
      end
    end
  end

  initial begin
    clr  = 1'b1;
    req  = '0;
    lock = 1'b0;
    for (int i = 0; i < NSRC; i++) srcVal[i] = 32'h0000_00A5 + (i << 8);
    repeat (2) @(posedge clk);
    #1;
    chk("init.gnt",   64'(gnt),      64'd0);
    chk("init.bus",   64'(busOut),   64'd0);
    chk("init.valid", 64'(busValid), 64'd0);
    clr = 1'b0;

    // Single requester, then release, then lock while idle.
    add(1, 24'h000001, 0, 24'h000001, 1, 0, 0);
    add(0, 24'h000000, 0, 24'h000000, 0, 0, 0);
    add(0, 24'h000000, 1, 24'h000000, 0, 0, 0);
    // src0 and src2 rotate every MAX_HOLD cycles.
    add(1, 24'h000005, 0, 24'h000001, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 24'h000005, 0, 24'h000001, 1, 0, 0);
    add(0, 24'h000005, 0, 24'h000004, 1, 1, 2);
    for (int i = 0; i < 3; i++) add(0, 24'h000005, 0, 24'h000004, 1, 0, 2);
    add(0, 24'h000005, 0, 24'h000001, 1, 1, 0);
    add(0, 24'h000005, 0, 24'h000001, 1, 0, 0);
    // lock extends src0 to 10 cycles. After that, lock cannot hold a dropped req.
    add(1, 24'h000005, 1, 24'h000001, 1, 0, 0);
    for (int i = 0; i < 9; i++) add(0, 24'h000005, 1, 24'h000001, 1, 0, 0);
    add(0, 24'h000005, 0, 24'h000004, 1, 1, 2);
    add(0, 24'h000001, 1, 24'h000001, 1, 1, 0);
    // Wrap-around handover from src23 to src0.
    add(1, 24'h800000, 0, 24'h800000, 1, 0, 23);
    add(0, 24'h800001, 0, 24'h800000, 1, 0, 23);
    add(0, 24'h000001, 0, 24'h000001, 1, 1, 0);
    // Lone src7 holds indefinitely, then releases and bus_out holds.
    add(1, 24'h000080, 0, 24'h000080, 1, 0, 7);
    for (int i = 0; i < 6; i++) add(0, 24'h000080, 0, 24'h000080, 1, 0, 7);
    add(0, 24'h000000, 0, 24'h000000, 0, 0, 7);
    add(0, 24'h000000, 1, 24'h000000, 0, 0, 7);
    // Priority resumes after src7, so src8 beats src0.
    add(0, 24'h000101, 0, 24'h000100, 1, 0, 8);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) pulseClr($sformatf("v%0d", i));
      step(vecs[i].req, vecs[i].lock, vecs[i].gnt, vecs[i].valid, vecs[i].ho,
           srcVal[vecs[i].busSrc], $sformatf("v%0d", i));
    end

    // Asynchronous clear in the middle of src5's tenure.
    pulseClr("seq6a");
    step(24'h000020, 0, 24'h000020, 1, 0, srcVal[5], "seq6.own5");
    step(24'h000020, 0, 24'h000020, 1, 0, srcVal[5], "seq6.hold5");
    req = 24'h000021;
    pulseClr("seq6.mid");
    step(24'h000021, 0, 24'h000001, 1, 0, srcVal[0], "seq6.src0first");

    // bus_out follows the owner's data on every edge.
    srcVal[0] = 32'h1234_5678;
    step(24'h000021, 0, 24'h000001, 1, 0, 32'h1234_5678, "track.d0");

    chk("sb.empty", 64'(sb.size()), 64'd0);
    req = '0;
    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
